// File: rtl/jtkicker_dwnld_pkg.sv
// jtkicker_dwnld_pkg: shared types and helpers for the ROM download remapper.
package jtkicker_dwnld_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam int REGION_W = 2;
  localparam int SWZ_W = 5;
  function automatic logic [SWZ_W-1:0] swz(input logic [SWZ_W-1:0] w);
    return {w[2:0], ~w[4], ~w[3]};
  endfunction
  typedef struct packed {
    logic [21:0]         addr;
    logic [7:0]          dat;
    logic [1:0]          mask;
    logic [REGION_W-1:0] region;
  } wr_t;
endpackage

// File: rtl/jtkicker_prog_map.sv
// jtkicker_prog_map: combinational region decode, object-bit swizzle and lane mask.
module jtkicker_prog_map
  import jtkicker_dwnld_pkg::*;
#(
  parameter int              REGIONS   = 4,
  parameter logic [4*22-1:0] REG_START = '0,
  parameter logic [3:0]      REG_SWZ   = '0,
  parameter bit              SWAB      = 1'b1
) (
  input  logic [21:0]         addr_i,
  output logic [21:0]         waddr_o,
  output logic [1:0]          mask_o,
  output logic [REGION_W-1:0] region_o
);
  logic [20:0] w;
  always_comb begin
    region_o = '0;
    for (int r = 1; r < REGIONS; r++)
      if (addr_i >= REG_START[r*22 +: 22]) region_o = REGION_W'(r);
    w = addr_i[21:1];
    waddr_o = {1'b0, REG_SWZ[region_o] ? {w[20:5], swz(w[4:0])} : w};
    mask_o = (addr_i[0] ^ SWAB) ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/jtkicker_prog_remap.sv
// jtkicker_prog_remap: turns ioctl byte writes into SDRAM prog requests with a 1-entry buffer.
// Signature flag capture is built only when JTKICKER_DWNLD_SIG_EN is defined.
module jtkicker_prog_remap
  import jtkicker_dwnld_pkg::*;
#(
  parameter int              REGIONS   = 4,
  parameter logic [4*22-1:0] REG_START = '0,
  parameter logic [3:0]      REG_SWZ   = '0,
  parameter bit              SWAB      = 1'b1,
  parameter logic [21:0]     FLAG_ADDR = '0,
  parameter int              FLAG_N    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [21:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  input  logic              sdram_ack,
  output logic [21:0]       prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  output logic [1:0]        region,
  output logic [FLAG_N-1:0] flags,
  output logic              dwnld_busy,
  output logic              overrun
);
  localparam wr_t WR_RST = '{addr: '0, dat: '0, mask: 2'b11, region: '0};
  state_t state_q, state_d;
  wr_t out_q, out_d, buf_q, buf_d, new_w;
  logic buf_v_q, buf_v_d, ovr_q, ovr_d, dl_q;
  logic [21:0] m_addr;
  logic [1:0] m_mask;
  logic [REGION_W-1:0] m_region;
  logic wr_ok, rise;

  jtkicker_prog_map #(
    .REGIONS(REGIONS), .REG_START(REG_START), .REG_SWZ(REG_SWZ), .SWAB(SWAB)
  ) u_map (
    .addr_i(ioctl_addr), .waddr_o(m_addr), .mask_o(m_mask), .region_o(m_region)
  );

  assign wr_ok = downloading & ioctl_wr;
  assign rise  = downloading & ~dl_q;
  assign new_w = '{addr: m_addr, dat: ioctl_dout, mask: m_mask, region: m_region};

  // An ack frees the buffer before a same-cycle write is considered, so that write never overruns.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    buf_d   = buf_q;
    buf_v_d = buf_v_q;
    ovr_d   = rise ? 1'b0 : ovr_q;
    if (state_q == IDLE) begin
      if (wr_ok) begin
        out_d   = new_w;
        state_d = REQ;
      end
    end else if (sdram_ack) begin
      if (buf_v_q) begin
        out_d   = buf_q;
        buf_d   = new_w;
        buf_v_d = wr_ok;
      end else if (wr_ok) out_d = new_w;
      else state_d = IDLE;
    end else if (wr_ok) begin
      if (buf_v_q) ovr_d = 1'b1;
      else begin
        buf_d   = new_w;
        buf_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= WR_RST;
      buf_q   <= WR_RST;
      buf_v_q <= 1'b0;
      ovr_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
      ovr_q   <= ovr_d;
      dl_q    <= downloading;
    end
  end

  assign prog_we    = state_q == REQ;
  assign prog_addr  = out_q.addr;
  assign prog_data  = {out_q.dat, out_q.dat};
  assign prog_mask  = out_q.mask;
  assign region     = out_q.region;
  assign overrun    = ovr_q;
  assign dwnld_busy = rst_n & (downloading | state_q == REQ);

`ifdef JTKICKER_DWNLD_SIG_EN
  logic [FLAG_N-1:0] flags_q;
  logic [21:0] foff;
  assign foff = ioctl_addr - FLAG_ADDR;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else if (rise) flags_q <= '0;
    else
      for (int k = 0; k < FLAG_N; k++)
        if (wr_ok && foff == 22'(k)) flags_q[k] <= &ioctl_dout;
  end
  assign flags = flags_q;
`else
  logic unused_flag_addr;
  assign unused_flag_addr = ^FLAG_ADDR;
  assign flags = '0;
`endif
endmodule

// File: tb/tb_jtkicker_prog_remap.sv
// tb_jtkicker_prog_remap: directed checks of remapping, buffering, overrun, busy, flags and reset.
module tb_jtkicker_prog_remap;
  logic clk = 1'b0, rst_n = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0, sdram_ack = 1'b0;
  logic [21:0] ioctl_addr = '0, prog_addr;
  logic [7:0] ioctl_dout = '0;
  logic [15:0] prog_data;
  logic [1:0] prog_mask, region, flags;
  logic prog_we, dwnld_busy, overrun;
  int errs = 0, checks = 0;
`ifdef JTKICKER_DWNLD_SIG_EN
  localparam logic [1:0] EXP_FLAGS = 2'b01;
`else
  localparam logic [1:0] EXP_FLAGS = 2'b00;
`endif

  jtkicker_prog_remap #(
    .REGIONS(4), .REG_START({22'h18000, 22'h10000, 22'h08000, 22'h0}),
    .REG_SWZ(4'b0100), .SWAB(1'b1), .FLAG_ADDR(22'h1C001), .FLAG_N(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .sdram_ack(sdram_ack),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .region(region), .flags(flags), .dwnld_busy(dwnld_busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
  endtask

  task automatic ack;
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_we"}, prog_we, 0);
    chk({tag, "_addr"}, prog_addr, 0);
    chk({tag, "_data"}, prog_data, 0);
    chk({tag, "_mask"}, prog_mask, 2'b11);
    chk({tag, "_region"}, region, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_busy"}, dwnld_busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_rst("rst");
    #10 rst_n = 1'b1;
    tick;
    downloading = 1'b1;
    tick;
    chk("busy_dl", dwnld_busy, 1);
    // swizzled region
    wr(22'h10005, 8'hA5);
    chk("swz_we", prog_we, 1);
    chk("swz_addr", prog_addr, 22'h800B);
    chk("swz_mask", prog_mask, 2'b10);
    chk("swz_data", prog_data, 16'hA5A5);
    chk("swz_region", region, 2);
    ack;
    chk("swz_done", prog_we, 0);
    // plain region
    wr(22'h08001, 8'h3C);
    chk("r1_addr", prog_addr, 22'h4000);
    chk("r1_mask", prog_mask, 2'b10);
    chk("r1_region", region, 1);
    chk("r1_data", prog_data, 16'h3C3C);
    ack;
    // three writes, no ack
    wr(22'h00010, 8'h11);
    wr(22'h00020, 8'h22);
    wr(22'h00030, 8'h33);
    chk("ovr_set", overrun, 1);
    chk("ovr_addr0", prog_addr, 22'h8);
    tick;
    chk("ovr_hold", prog_addr, 22'h8);
    chk("ovr_hold_we", prog_we, 1);
    ack;
    chk("ovr_addr1", prog_addr, 22'h10);
    chk("ovr_data1", prog_data, 16'h2222);
    chk("ovr_we1", prog_we, 1);
    ack;
    chk("ovr_we_end", prog_we, 0);
    repeat (2) tick;
    chk("ovr_no_third", prog_we, 0);
    chk("ovr_sticky", overrun, 1);
    // ack coinciding with a write while the buffer is full
    wr(22'h00050, 8'h55);
    wr(22'h00060, 8'h66);
    ioctl_addr = 22'h00070;
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    sdram_ack = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    sdram_ack = 1'b0;
    chk("coin_addr", prog_addr, 22'h30);
    ack;
    chk("coin_addr2", prog_addr, 22'h38);
    chk("coin_we2", prog_we, 1);
    ack;
    chk("coin_end", prog_we, 0);
    // flush after downloading falls
    wr(22'h00040, 8'h44);
    downloading = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("flush_busy", dwnld_busy, 1);
    end
    sdram_ack = 1'b1;
    chk("flush_busy_ack", dwnld_busy, 1);
    tick;
    sdram_ack = 1'b0;
    chk("flush_busy_end", dwnld_busy, 0);
    chk("flush_we_end", prog_we, 0);
    ioctl_wr = 1'b1;
    tick;
    ioctl_wr = 1'b0;
    chk("ignore_wr", prog_we, 0);
    chk("ovr_idle", overrun, 1);
    downloading = 1'b1;
    tick;
    chk("ovr_clear", overrun, 0);
    // signature flags
    wr(22'h1C001, 8'hFF);
    chk("sig_region", region, 3);
    chk("sig_addr", prog_addr, 22'hE000);
    ack;
    wr(22'h1C002, 8'h7F);
    chk("sig_flags", flags, EXP_FLAGS);
    ack;
    downloading = 1'b0;
    tick;
    downloading = 1'b1;
    tick;
    chk("sig_clear", flags, 0);
    // reset with REQ pending and buffer full
    wr(22'h00080, 8'h88);
    wr(22'h00090, 8'h99);
    #2 rst_n = 1'b0;
    #1 chk_rst("arst");
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_we", prog_we, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
